pam4_mapper_ref_track: RTL and testbench

- Registered, parametrised 4-PAM mapper and slicer with a tracked reference level.
- Maps Gray symbols to signed levels in fixed full-scale mode or reference-scaled mode.
- Slices received samples against the tracked reference and outputs the decision error.
- Sits between the LFSR/symbol source and the receive slicer/equaliser path; the reference level is estimated from the mean absolute value of received samples.

---
 rtl/pam4_mapper_ref_track.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_pam4_mapper_ref_track.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pam4_mapper_ref_track.sv
// -----------------------------------------------------------------------------
// pam4_mapper_ref_track
//
// Registered 4-PAM mapper and slicer sharing one tracked reference level.
//
//   * Mapper : Gray symbol -> signed level. In mode 0 the levels are fixed
//              full-scale values; in mode 1 they are scaled from the tracked
//              reference r (inner = r/2, outer = 3r/2 saturated).
//   * Slicer : rx_sample -> Gray decision using thresholds 0 and +/-r, plus the
//              saturated decision error rx_sample - level(decision).
//   * Tracker: r is re-estimated every 2^ACC_LOG2 strobes as the mean of
//              |rx_sample| over the window (r = 2d where 3d is the outer level).
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   sym_en     in   symbol strobe; all inputs are sampled only when high
//   mode       in   0 = fixed full-scale levels, 1 = reference-scaled levels
//   sym_in     in   [1:0] Gray symbol to map
//   rx_sample  in   [WIDTH-1:0] signed received sample
//   map_out    out  [WIDTH-1:0] signed mapped level of sym_in
//   slice_out  out  [1:0] Gray decision for rx_sample
//   err_out    out  [WIDTH-1:0] signed, saturated decision error
//   out_valid  out  one-cycle pulse one clock after each strobe
//   ref_lvl    out  [WIDTH-1:0] tracked reference (non-negative)
//   ref_valid  out  high once the first averaging window has completed
// -----------------------------------------------------------------------------
module pam4_mapper_ref_track #(
    parameter int WIDTH    = 18,
    parameter int ACC_LOG2 = 10,
    parameter int REF_INIT = 87381
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sym_en,
    input  logic                    mode,
    input  logic [1:0]              sym_in,
    input  logic signed [WIDTH-1:0] rx_sample,
    output logic signed [WIDTH-1:0] map_out,
    output logic [1:0]              slice_out,
    output logic signed [WIDTH-1:0] err_out,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] ref_lvl,
    output logic                    ref_valid
);

    localparam int ACC_W = WIDTH + ACC_LOG2;

    // Full-scale extremes of the signed WIDTH-bit range.
    localparam logic signed [WIDTH-1:0] LVL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] LVL_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    // Same extremes sign-extended by one bit for saturation compares.
    localparam logic signed [WIDTH:0]   LVL_MAX_X = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0]   LVL_MIN_X = {2'b11, {(WIDTH-1){1'b0}}};

    // round(2^(WIDTH-1)/3): 2^k is never a multiple of 3, so adding 1 before
    // the truncating divide rounds to nearest in both residue cases.
    localparam int INNER_INT = ((2 ** (WIDTH - 1)) + 1) / 3;
    localparam logic signed [WIDTH-1:0] LVL_INNER0 = WIDTH'(INNER_INT);
    localparam logic signed [WIDTH-1:0] REF_INIT_V = WIDTH'(REF_INIT);

    typedef enum logic [0:0] {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Saturate a WIDTH+1-bit signed value into the WIDTH-bit signed range.
    function automatic logic signed [WIDTH-1:0] sat_fn(input logic signed [WIDTH:0] v);
        logic signed [WIDTH-1:0] res;
        if (v > LVL_MAX_X) begin
            res = LVL_MAX;
        end else if (v < LVL_MIN_X) begin
            res = LVL_MIN;
        end else begin
            res = v[WIDTH-1:0];
        end
        return res;
    endfunction

    // Magnitude as WIDTH-bit unsigned; the most negative input maps exactly
    // to 2^(WIDTH-1) because the result is read back unsigned.
    function automatic logic [WIDTH-1:0] abs_fn(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        if (v[WIDTH-1] == 1'b1) begin
            res = ~v + WIDTH'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Level for a Gray symbol in the selected mode; r is always non-negative.
    function automatic logic signed [WIDTH-1:0] gray_level(
        input logic [1:0]              sym,
        input logic                    md,
        input logic signed [WIDTH-1:0] r
    );
        logic signed [WIDTH-1:0] inner;
        logic signed [WIDTH-1:0] outer;
        logic signed [WIDTH:0]   r_x;
        logic signed [WIDTH:0]   inner_x;
        logic signed [WIDTH:0]   outer_x;
        logic signed [WIDTH-1:0] lvl;
        inner   = r >>> 1;
        r_x     = {r[WIDTH-1], r};
        inner_x = {inner[WIDTH-1], inner};
        outer_x = r_x + inner_x;
        if (outer_x > LVL_MAX_X) begin
            outer = LVL_MAX;
        end else begin
            outer = outer_x[WIDTH-1:0];
        end
        if (md == 1'b0) begin
            case (sym)
                2'b00:   lvl = LVL_MIN;
                2'b01:   lvl = -LVL_INNER0;
                2'b11:   lvl = LVL_INNER0;
                2'b10:   lvl = LVL_MAX;
                default: lvl = LVL_MIN;
            endcase
        end else begin
            case (sym)
                2'b00:   lvl = -outer;
                2'b01:   lvl = -inner;
                2'b11:   lvl = inner;
                2'b10:   lvl = outer;
                default: lvl = -outer;
            endcase
        end
        return lvl;
    endfunction

    // Threshold slicer: >= r -> 10, [0,r) -> 11, [-r,0) -> 01, below -> 00.
    // Compares are done one bit wider so -r never overflows.
    function automatic logic [1:0] slice_fn(
        input logic signed [WIDTH-1:0] rx,
        input logic signed [WIDTH-1:0] r
    );
        logic signed [WIDTH:0] rx_x;
        logic signed [WIDTH:0] r_x;
        logic signed [WIDTH:0] nr_x;
        logic [1:0]            dec;
        rx_x = {rx[WIDTH-1], rx};
        r_x  = {r[WIDTH-1], r};
        nr_x = -r_x;
        if (rx_x >= r_x) begin
            dec = 2'b10;
        end else if (rx[WIDTH-1] == 1'b0) begin
            dec = 2'b11;
        end else if (rx_x >= nr_x) begin
            dec = 2'b01;
        end else begin
            dec = 2'b00;
        end
        return dec;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state_q,   state_d;
    logic [ACC_W-1:0]        acc_q,     acc_d;
    logic [ACC_LOG2-1:0]     cnt_q,     cnt_d;
    logic signed [WIDTH-1:0] ref_q,     ref_d;
    logic signed [WIDTH-1:0] map_q,     map_d;
    logic [1:0]              slice_q,   slice_d;
    logic signed [WIDTH-1:0] err_q,     err_d;
    logic                    valid_q,   valid_d;

    logic signed [WIDTH-1:0] level_s;
    logic [1:0]              slice_s;
    logic signed [WIDTH-1:0] slice_lvl_s;
    logic signed [WIDTH:0]   rx_x_s;
    logic signed [WIDTH:0]   lvl_x_s;
    logic signed [WIDTH:0]   diff_s;
    logic signed [WIDTH-1:0] err_s;
    logic [WIDTH-1:0]        abs_s;
    logic [ACC_W-1:0]        acc_sum_s;
    logic                    win_close_s;
    logic signed [WIDTH-1:0] new_ref_s;
    logic                    ref_valid_s;

    // Mapper, slicer and decision-error datapath, all against the current reference.
    always_comb begin
        level_s     = gray_level(sym_in, mode, ref_q);
        slice_s     = slice_fn(rx_sample, ref_q);
        slice_lvl_s = gray_level(slice_s, mode, ref_q);
        rx_x_s      = {rx_sample[WIDTH-1], rx_sample};
        lvl_x_s     = {slice_lvl_s[WIDTH-1], slice_lvl_s};
        diff_s      = rx_x_s - lvl_x_s;
        err_s       = sat_fn(diff_s);
    end

    // Window accumulation and the reference estimate produced at window close.
    always_comb begin
        abs_s       = abs_fn(rx_sample);
        acc_sum_s   = acc_q + {{ACC_LOG2{1'b0}}, abs_s};
        win_close_s = sym_en && (cnt_q == {ACC_LOG2{1'b1}});
        // The mean can only reach 2^(WIDTH-1) when every sample was full-scale
        // negative; that single out-of-range value sets the top sum bit.
        if (acc_sum_s[ACC_W-1] == 1'b1) begin
            new_ref_s = LVL_MAX;
        end else begin
            new_ref_s = acc_sum_s[ACC_W-1:ACC_LOG2];
        end
    end

    // Next-state for tracker and output registers; everything holds without a strobe.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        map_d   = map_q;
        slice_d = slice_q;
        err_d   = err_q;
        valid_d = 1'b0;
        if (sym_en) begin
            map_d   = level_s;
            slice_d = slice_s;
            err_d   = err_s;
            valid_d = 1'b1;
            cnt_d   = cnt_q + ACC_LOG2'(1);
            if (win_close_s) begin
                acc_d = {ACC_W{1'b0}};
                ref_d = new_ref_s;
            end else begin
                acc_d = acc_sum_s;
                ref_d = ref_q;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Datapath and tracker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {ACC_LOG2{1'b0}};
            ref_q   <= REF_INIT_V;
            map_q   <= {WIDTH{1'b0}};
            slice_q <= 2'b00;
            err_q   <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            map_q   <= map_d;
            slice_q <= slice_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Tracking FSM: ACQUIRE until the first window closes, then TRACK forever.
    // -------------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACQUIRE: begin
                if (win_close_s) begin
                    state_d = ST_TRACK;
                end else begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_TRACK: state_d = ST_TRACK;
            default:  state_d = ST_ACQUIRE;
        endcase
    end

    // FSM output decode; a direct decode of the state flop keeps it glitch-free.
    always_comb begin
        ref_valid_s = 1'b0;
        case (state_q)
            ST_ACQUIRE: ref_valid_s = 1'b0;
            ST_TRACK:   ref_valid_s = 1'b1;
            default:    ref_valid_s = 1'b0;
        endcase
    end

    assign map_out   = map_q;
    assign slice_out = slice_q;
    assign err_out   = err_q;
    assign out_valid = valid_q;
    assign ref_lvl   = ref_q;
    assign ref_valid = ref_valid_s;

endmodule

// File: tb/tb_pam4_mapper_ref_track.sv
// Testbench for pam4_mapper_ref_track with WIDTH=18, ACC_LOG2=2 (4-symbol window).
module tb_pam4_mapper_ref_track;

    localparam int W    = 18;
    localparam int ACC  = 2;
    localparam int NWIN = 4;
    localparam int RINI = 87381;
    localparam int VMAX = 131071;
    localparam int VMIN = -131072;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                sym_en = 1'b0;
    logic                mode = 1'b0;
    logic [1:0]          sym_in = 2'b00;
    logic signed [W-1:0] rx_sample = '0;
    logic signed [W-1:0] map_out;
    logic [1:0]          slice_out;
    logic signed [W-1:0] err_out;
    logic                out_valid;
    logic signed [W-1:0] ref_lvl;
    logic                ref_valid;

    pam4_mapper_ref_track #(.WIDTH(W), .ACC_LOG2(ACC), .REF_INIT(RINI)) dut (
        .clk(clk), .reset(reset), .sym_en(sym_en), .mode(mode), .sym_in(sym_in),
        .rx_sample(rx_sample), .map_out(map_out), .slice_out(slice_out),
        .err_out(err_out), .out_valid(out_valid), .ref_lvl(ref_lvl), .ref_valid(ref_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_ref, m_sum, m_cnt;
    bit m_rv;
    int h_map, h_slice, h_err;

    task automatic model_reset();
        m_ref = RINI; m_sum = 0; m_cnt = 0; m_rv = 0;
        h_map = 0; h_slice = 0; h_err = 0;
    endtask

    function automatic int model_level(input logic [1:0] s, input bit md, input int r);
        int mag;
        int sgn;
        sgn = (s == 2'b00 || s == 2'b01) ? -1 : 1;
        if (md == 1'b0) begin
            mag = (s == 2'b01 || s == 2'b11) ? 43691 : ((sgn < 0) ? 131072 : 131071);
        end else begin
            mag = (s == 2'b01 || s == 2'b11) ? r / 2 : r + r / 2;
            if (mag > VMAX) mag = VMAX;
        end
        return sgn * mag;
    endfunction

    function automatic logic [1:0] model_slice(input int rx, input int r);
        if (rx >= r)       return 2'b10;
        else if (rx >= 0)  return 2'b11;
        else if (rx >= -r) return 2'b01;
        else               return 2'b00;
    endfunction

    function automatic int clamp(input int v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input bit md, input logic [1:0] s, input int rx);
        @(negedge clk);
        sym_en = 1'b1; mode = md; sym_in = s; rx_sample = W'(rx);
        @(posedge clk);
        #1;
        sym_en = 1'b0;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        reset = 1'b1; sym_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("rst_map",   int'(map_out), 0);
        chk("rst_slice", int'(slice_out), 0);
        chk("rst_err",   int'(err_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ref",   int'(ref_lvl), RINI);
        chk("rst_rv",    int'(ref_valid), 0);
    endtask

    // Strobe checked against the model; the closing symbol uses the old reference.
    task automatic strobe_model(input bit md, input logic [1:0] s, input int rx);
        int lvl, er;
        logic [1:0] sl;
        lvl = model_level(s, md, m_ref);
        sl  = model_slice(rx, m_ref);
        er  = clamp(rx - model_level(sl, md, m_ref));
        m_sum += (rx < 0) ? -rx : rx;
        m_cnt++;
        if (m_cnt == NWIN) begin
            m_ref = (m_sum / NWIN > VMAX) ? VMAX : m_sum / NWIN;
            m_sum = 0; m_cnt = 0; m_rv = 1;
        end
        h_map = lvl; h_slice = int'(sl); h_err = er;
        drive(md, s, rx);
        chk("m_valid", int'(out_valid), 1);
        chk("m_map",   int'(map_out), h_map);
        chk("m_slice", int'(slice_out), h_slice);
        chk("m_err",   int'(err_out), h_err);
        chk("m_ref",   int'(ref_lvl), m_ref);
        chk("m_rv",    int'(ref_valid), int'(m_rv));
    endtask

    task automatic idle_check();
        @(posedge clk);
        #1;
        chk("idle_valid", int'(out_valid), 0);
        chk("idle_map",   int'(map_out), h_map);
        chk("idle_slice", int'(slice_out), h_slice);
        chk("idle_err",   int'(err_out), h_err);
        chk("idle_ref",   int'(ref_lvl), m_ref);
        chk("idle_rv",    int'(ref_valid), int'(m_rv));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         md;
        logic [1:0] s;
        int         rx;
        int         e_map;
        logic [1:0] e_slice;
        int         e_err;
        int         e_ref;
        bit         e_rv;
    } vec_t;

    vec_t vt[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Mode 0 mapping; ref 87381 then rx=0 window gives ref 0, then r=0 in mode 1.
        vt.push_back('{1'b1, 1'b0, 2'b00, 0, -131072, 2'b11, -43691, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b0, 2'b01, 0,  -43691, 2'b11, -43691, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b0, 2'b11, 0,   43691, 2'b11, -43691, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b0, 2'b10, 0,  131071, 2'b11, -43691,     0, 1'b1});
        vt.push_back('{1'b0, 1'b1, 2'b10, 0,       0, 2'b10,      0,     0, 1'b1});
        vt.push_back('{1'b0, 1'b1, 2'b00, -1,      0, 2'b00,     -1,     0, 1'b1});
        // Mode 1 tracking to 80000.
        vt.push_back('{1'b1, 1'b1, 2'b00,  40000, -131071, 2'b11,  -3690, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'b01, -40000,  -43690, 2'b01,   3690, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'b11, 120000,   43690, 2'b10, -11071, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'b10, -120000, 131071, 2'b00,  11071, 80000, 1'b1});
        vt.push_back('{1'b0, 1'b1, 2'b10,  79999,  120000, 2'b11,  39999, 80000, 1'b1});
        vt.push_back('{1'b0, 1'b1, 2'b01,      0,  -40000, 2'b11, -40000, 80000, 1'b1});
        // Saturation of the reference and of the outer level.
        vt.push_back('{1'b1, 1'b1, 2'b00, -131072, -131071, 2'b00,    -1, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'b00, -131072, -131071, 2'b00,    -1, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'b00, -131072, -131071, 2'b00,    -1, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'b00, -131072, -131071, 2'b00,    -1, 131071, 1'b1});
        vt.push_back('{1'b0, 1'b1, 2'b10, -131072,  131071, 2'b00,    -1, 131071, 1'b1});
        vt.push_back('{1'b0, 1'b1, 2'b11,       0,   65535, 2'b11, -65535, 131071, 1'b1});
        // Slicer boundaries at ref 87381.
        vt.push_back('{1'b1, 1'b0, 2'b00,      0, -131072, 2'b11, -43691, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b0, 2'b00,  87381, -131072, 2'b10, -43690, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b0, 2'b00, -87381, -131072, 2'b01, -43690, 87381, 1'b0});
        vt.push_back('{1'b0, 1'b0, 2'b00, -87382, -131072, 2'b00,  43690, 65536, 1'b1});

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) begin
            if (vt[i].rst) hard_reset();
            drive(vt[i].md, vt[i].s, vt[i].rx);
            chk($sformatf("v%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("v%0d_map", i),   int'(map_out), vt[i].e_map);
            chk($sformatf("v%0d_slice", i), int'(slice_out), int'(vt[i].e_slice));
            chk($sformatf("v%0d_err", i),   int'(err_out), vt[i].e_err);
            chk($sformatf("v%0d_ref", i),   int'(ref_lvl), vt[i].e_ref);
            chk($sformatf("v%0d_rv", i),    int'(ref_valid), int'(vt[i].e_rv));
            // out_valid must be a single-cycle pulse
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse", i), int'(out_valid), 0);
        end

        // Asynchronous reset mid-window discards the partial sum.
        hard_reset();
        strobe_model(1'b0, 2'b00, 1000);
        strobe_model(1'b0, 2'b10, 1000);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_map", int'(map_out), 0);
        chk("async_ref", int'(ref_lvl), RINI);
        chk("async_rv",  int'(ref_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) strobe_model(1'b1, 2'b11, 60000);
        chk("rstwin_ref", int'(ref_lvl), 60000);
        chk("rstwin_rv",  int'(ref_valid), 1);

        // Randomised rounds: back-to-back, then with 0..5 idle gaps.
        for (int rnd = 0; rnd < 4; rnd++) begin
            hard_reset();
            for (int k = 0; k < 24; k++) begin
                int rx;
                case ($urandom_range(0, 7))
                    0:       rx = m_ref;
                    1:       rx = -m_ref;
                    2:       rx = m_ref - 1;
                    3:       rx = -m_ref - 1;
                    4:       rx = 0;
                    5:       rx = VMIN;
                    default: rx = int'($urandom_range(0, 262143)) - 131072;
                endcase
                strobe_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rx);
                if (rnd >= 2) begin
                    int gap;
                    gap = int'($urandom_range(0, 5));
                    for (int g = 0; g < gap; g++) idle_check();
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
